sort_sequencer: RTL and testbench

- Serial in-place sorter for up to NUM_WORDS 16-bit words.
- The team's existing 16-bit magnitude comparator (gt/lt/eq outputs) is instantiated exactly once and time-shared across all compare steps.
- Bubble sort with early exit: one compare-and-swap per cycle.
- Sits between a word-serial producer (load side) and a word-serial consumer (read side).

---
 rtl/sort_pkg.sv | 18 +
 rtl/sort_sequencer_cmp.sv | 19 +
 rtl/sort_sequencer.sv | 176 +++++++++++++++++
 tb/tb_sort_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizing for the serial bubble sorter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sort_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_WORDS  = 8;
  localparam int PTR_WIDTH  = 3;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2,
    READ = 2'd3
  } state_e;

endpackage

// File: rtl/sort_sequencer_cmp.sv
// 16-bit unsigned magnitude comparator: gt/lt/eq of a versus b.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a, b operands; gt = a>b, lt = a<b, eq = a==b.
module sort_sequencer_cmp
  import sort_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt,
  output logic                  lt,
  output logic                  eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/sort_sequencer.sv
// Serial in-place bubble sorter with early exit, one compare-and-swap per cycle.
// Latency: start -> busy next cycle; worst case count*(count-1)/2 SORT cycles, then one done cycle.
// Backpressure: load/start only honoured in IDLE, read_en only in READ; ignored elsewhere.
// Ports: clk/n_rst (sync active-low); load_en/load_data fill buffer; start/ascending launch sort;
//        read_en pops sorted words to read_data/read_valid; busy/done/full/swap_count status.
module sort_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load_en,
  input  logic [15:0] load_data,
  input  logic        start,
  input  logic        ascending,
  input  logic        read_en,
  output logic        busy,
  output logic        done,
  output logic        full,
  output logic [15:0] read_data,
  output logic        read_valid,
  output logic [7:0]  swap_count
);

  import sort_pkg::*;

  localparam logic [CNT_WIDTH-1:0] NUM_W   = CNT_WIDTH'(NUM_WORDS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO = CNT_WIDTH'(2);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [PTR_WIDTH-1:0]   i_q, i_d;
  logic [PTR_WIDTH-1:0]   pass_q, pass_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic                   swapped_q, swapped_d;
  logic                   asc_q, asc_d;
  logic [7:0]             swap_count_q, swap_count_d;
  logic [DATA_WIDTH-1:0]  read_data_q, read_data_d;
  logic                   read_valid_q, read_valid_d;
  logic [DATA_WIDTH-1:0]  buf_q [MAX_WORDS];
  logic [DATA_WIDTH-1:0]  buf_d [MAX_WORDS];

  logic [DATA_WIDTH-1:0]  cmp_a, cmp_b;
  logic                   cmp_gt, cmp_lt, cmp_eq;
  logic                   do_swap;
  logic                   any_swap;
  logic                   last_step;
  logic                   last_pass;
  logic [CNT_WIDTH-1:0]   cnt_ld;

  // Single shared comparator always looks at the current adjacent pair.
  assign cmp_a = buf_q[i_q];
  assign cmp_b = buf_q[i_q + PTR_ONE];

  sort_sequencer_cmp u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (cmp_gt),
    .lt (cmp_lt),
    .eq (cmp_eq)
  );

  // Equal words never move, which keeps the sort stable.
  assign do_swap   = !cmp_eq && (asc_q ? cmp_gt : cmp_lt);
  assign any_swap  = swapped_q | do_swap;
  // Each pass parks one more word at the tail, so the inner range shrinks by pass.
  assign last_step = ({1'b0, i_q} >= (count_q - CNT_TWO - {1'b0, pass_q}));
  assign last_pass = ({1'b0, pass_q} == (count_q - CNT_TWO));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    i_d          = i_q;
    pass_d       = pass_q;
    rd_ptr_d     = rd_ptr_q;
    swapped_d    = swapped_q;
    asc_d        = asc_q;
    swap_count_d = swap_count_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    buf_d        = buf_q;
    cnt_ld       = count_q;

    case (state_q)
      IDLE: begin
        if (load_en && (count_q < NUM_W)) begin
          buf_d[count_q[PTR_WIDTH-1:0]] = load_data;
          cnt_ld = count_q + CNT_ONE;
        end
        count_d = cnt_ld;
        // start sees the count including a same-cycle load.
        if (start && (cnt_ld != '0)) begin
          asc_d        = ascending;
          swap_count_d = '0;
          pass_d       = '0;
          i_d          = '0;
          swapped_d    = 1'b0;
          state_d      = (cnt_ld >= CNT_TWO) ? SORT : DONE;
        end
      end
      SORT: begin
        if (do_swap) begin
          buf_d[i_q]           = cmp_b;
          buf_d[i_q + PTR_ONE] = cmp_a;
          swap_count_d         = swap_count_q + 8'd1;
        end
        if (!last_step) begin
          i_d       = i_q + PTR_ONE;
          swapped_d = any_swap;
        end else if (!any_swap || last_pass) begin
          state_d = DONE;
        end else begin
          pass_d    = pass_q + PTR_ONE;
          i_d       = '0;
          swapped_d = 1'b0;
        end
      end
      DONE: begin
        rd_ptr_d = '0;
        state_d  = READ;
      end
      READ: begin
        if (read_en) begin
          read_data_d  = buf_q[rd_ptr_q];
          read_valid_d = 1'b1;
          rd_ptr_d     = rd_ptr_q + PTR_ONE;
          if ({1'b0, rd_ptr_q} == (count_q - CNT_ONE)) begin
            count_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      i_q          <= '0;
      pass_q       <= '0;
      rd_ptr_q     <= '0;
      swapped_q    <= 1'b0;
      asc_q        <= 1'b0;
      swap_count_q <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      i_q          <= i_d;
      pass_q       <= pass_d;
      rd_ptr_q     <= rd_ptr_d;
      swapped_q    <= swapped_d;
      asc_q        <= asc_d;
      swap_count_q <= swap_count_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  // Buffer contents carry no reset meaning; only count qualifies them.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy       = (state_q == SORT);
  assign done       = (state_q == DONE);
  assign full       = (count_q == NUM_W);
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort_sequencer.sv
module tb_sort_sequencer;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        load_en;
  logic [15:0] load_data;
  logic        start;
  logic        ascending;
  logic        read_en;
  logic        busy;
  logic        done;
  logic        full;
  logic [15:0] read_data;
  logic        read_valid;
  logic [7:0]  swap_count;

  int tests = 0;
  int fails = 0;

  logic [15:0] ld [8];
  int          n_load;
  bit          noise;

  logic [15:0] exp_w [8];
  int          exp_swaps;
  int          exp_cycles;

  sort_sequencer #(.NUM_WORDS(NW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_en    (load_en),
    .load_data  (load_data),
    .start      (start),
    .ascending  (ascending),
    .read_en    (read_en),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .read_data  (read_data),
    .read_valid (read_valid),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: stable sort result, swaps = strict inversions, SORT cycles from
  // the number of bubble passes (largest left-inversion count of any word, plus
  // one clean pass, capped at m-1 passes).
  task automatic model(input int m, input bit asc);
    int maxleft;
    int left;
    int passes;
    logic [15:0] key;
    int k;
    exp_swaps  = 0;
    exp_cycles = 0;
    maxleft    = 0;
    for (int j = 0; j < m; j++) begin
      left = 0;
      for (int q = 0; q < j; q++)
        if (asc ? (ld[q] > ld[j]) : (ld[q] < ld[j])) left++;
      exp_swaps += left;
      if (left > maxleft) maxleft = left;
    end
    if (m >= 2) begin
      passes = (maxleft + 1 < m - 1) ? maxleft + 1 : m - 1;
      for (int p = 0; p < passes; p++) exp_cycles += m - 1 - p;
    end
    for (int j = 0; j < m; j++) exp_w[j] = ld[j];
    for (int j = 1; j < m; j++) begin
      key = exp_w[j];
      k = j - 1;
      while (k >= 0 && (asc ? (exp_w[k] > key) : (exp_w[k] < key))) begin
        exp_w[k+1] = exp_w[k];
        k--;
      end
      exp_w[k+1] = key;
    end
  endtask

  task automatic run_case(input string tag, input bit asc);
    int m;
    int cyc;
    m = (n_load < NW) ? n_load : NW;
    for (int j = 0; j < n_load; j++) begin
      load_en   = 1'b1;
      load_data = ld[j];
      tick();
      load_en   = 1'b0;
      if (j == NW - 1) chk({tag, "_full"}, full, 1'b1);
    end
    chk({tag, "_full_pre"}, full, (m == NW));
    model(m, asc);
    ascending = asc;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (noise) begin
        load_en   = 1'b1;
        start     = 1'b1;
        read_en   = 1'b1;
        ascending = ~asc;
        load_data = 16'(urand16());
      end
      cyc++;
      tick();
    end
    load_en = 1'b0; start = 1'b0; read_en = 1'b0; ascending = asc;
    chk({tag, "_sort_cycles"}, cyc, exp_cycles);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_swaps"}, swap_count, exp_swaps);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    for (int j = 0; j < m; j++) begin
      if ($urandom_range(1, 0) == 1) begin
        tick();
        chk({tag, "_idle_valid"}, read_valid, 1'b0);
      end
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      chk({tag, "_rvalid"}, read_valid, 1'b1);
      chk({tag, "_rdata"}, read_data, exp_w[j]);
    end
    tick();
    chk({tag, "_rvalid_end"}, read_valid, 1'b0);
    chk({tag, "_rdata_hold"}, read_data, exp_w[m-1]);
    chk({tag, "_full_end"}, full, 1'b0);
    chk({tag, "_swaps_held"}, swap_count, exp_swaps);
  endtask

  function automatic int urand16();
    return int'($urandom_range(16'hFFFF, 0));
  endfunction

  initial begin
    n_rst = 1'b0; load_en = 1'b0; load_data = '0; start = 1'b0;
    ascending = 1'b1; read_en = 1'b0; noise = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_rvalid", read_valid, 1'b0);
    chk("rst_rdata", read_data, 16'h0);
    chk("rst_swaps", swap_count, 8'h0);
    n_rst = 1'b1;
    tick();

    // Reverse input, full worst case.
    ld[0] = 16'd4; ld[1] = 16'd3; ld[2] = 16'd2; ld[3] = 16'd1; n_load = 4;
    run_case("rev", 1'b1);

    // Already sorted: early exit after one pass.
    ld[0] = 16'd1; ld[1] = 16'd2; ld[2] = 16'd3; ld[3] = 16'd4; n_load = 4;
    run_case("sorted", 1'b1);

    // Descending with duplicates and extremes.
    ld[0] = 16'h0005; ld[1] = 16'hFFFF; ld[2] = 16'h0005; ld[3] = 16'h0000; n_load = 4;
    run_case("desc_dup", 1'b0);

    // start with nothing loaded is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_busy", busy, 1'b0);
    chk("empty_done", done, 1'b0);
    tick();
    chk("empty_done2", done, 1'b0);

    // Single word goes straight to done.
    ld[0] = 16'h1234; n_load = 1;
    run_case("single", 1'b1);

    // Overfill plus noise on inputs while sorting.
    ld[0] = 16'd9; ld[1] = 16'd7; ld[2] = 16'd8; ld[3] = 16'd6; ld[4] = 16'd1; n_load = 5;
    noise = 1'b1;
    run_case("overfill_noise", 1'b1);
    noise = 1'b0;

    // Reset on the third SORT cycle aborts the sort.
    for (int j = 0; j < 4; j++) begin
      load_en = 1'b1; load_data = 16'(4 - j);
      tick();
    end
    load_en = 1'b0;
    ascending = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_busy_before", busy, 1'b1);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_full", full, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_swaps", swap_count, 8'h0);
    tick();
    chk("abort_done2", done, 1'b0);
    ld[0] = 16'd2; ld[1] = 16'd1; n_load = 2;
    run_case("after_abort", 1'b1);

    // Randomized cases, narrow value range to force ties.
    for (int t = 0; t < 8; t++) begin
      n_load = int'($urandom_range(NW, 2));
      for (int j = 0; j < n_load; j++) ld[j] = 16'($urandom_range(5, 0));
      run_case("rand", 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
